ext_int_source: RTL and testbench

- Programmable external-interrupt responder on the far side of the CPU's `interrupt` / `m_int_addr` / `m_int_byteen` interface.
- Raises `interrupt` on a schedule and holds it until the interrupt handler acknowledges it with a store to the acknowledge address.
- Counts serviced interrupts and flags spurious and late acknowledges.
- Instantiated in the system bench next to the mips top; drives its `interrupt` input and observes its interrupt-space write port.

---
 rtl/ext_int_source_if.sv | 32 +++
 rtl/ext_int_source.sv | 155 +++++++++++++++
 tb/tb_ext_int_source.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_int_source_if.sv
// ---------------------------------------------------------------------------
// ext_int_source_if
//
// Groups the CPU interrupt-space signals shared by the CPU and an
// external interrupt responder.
//
// Signals:
//   m_int_addr   [31:0]  CPU interrupt-space byte address.
//   m_int_byteen [3:0]   CPU interrupt-space byte enables (nonzero = store).
//   interrupt            Interrupt request from the responder to the CPU.
//
// Modports:
//   master  CPU side: drives address/byte enables, receives the interrupt.
//   slave   Responder side: observes address/byte enables, drives the interrupt.
// ---------------------------------------------------------------------------
interface ext_int_source_if;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;

    modport master (
        output m_int_addr,
        output m_int_byteen,
        input  interrupt
    );

    modport slave (
        input  m_int_addr,
        input  m_int_byteen,
        output interrupt
    );
endinterface

// File: rtl/ext_int_source.sv
// ---------------------------------------------------------------------------
// ext_int_source
//
// Programmable external-interrupt responder. It raises the CPU interrupt
// on a schedule, holds it until the handler stores to ACK_ADDR, counts
// serviced interrupts, and flags spurious and late acknowledges.
//
// Parameters:
//   ACK_ADDR     Byte address whose store acknowledges the interrupt.
//   FIRST_DELAY  Cycles from reset release to the first assertion (>= 1).
//   PERIOD       Cycles from an acknowledge to the next assertion (>= 1).
//   MAX_IRQ      Number of interrupts to raise; 0 means unlimited.
//   ACK_TIMEOUT  Pending cycles after which ack_late sets.
//   TRIG_PC      (only with EXT_INT_SOURCE_PC_TRIG_EN) PC that triggers
//                an immediate interrupt while counting.
//
// Ports:
//   clk             in   System clock, rising edge.
//   reset           in   Asynchronous, active-low reset.
//   bus             if   ext_int_source_if.slave (address, byte enables,
//                        registered interrupt output).
//   irq_count       out  Interrupts acknowledged so far, saturates at 255.
//   spurious_ack    out  One-cycle pulse on an acknowledge while not pending.
//   ack_late        out  Sticky flag: a pending interrupt waited too long.
//   macroscopic_pc  in   (only with EXT_INT_SOURCE_PC_TRIG_EN) CPU PC.
//
// Configuration macro:
//   EXT_INT_SOURCE_PC_TRIG_EN  When defined, adds macroscopic_pc/TRIG_PC and
//                              lets a PC match trigger the interrupt early.
//                              When undefined, triggering is time-based only.
// ---------------------------------------------------------------------------
module ext_int_source #(
    parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
    parameter int unsigned FIRST_DELAY = 100,
    parameter int unsigned PERIOD      = 500,
    parameter int unsigned MAX_IRQ     = 8,
    parameter int unsigned ACK_TIMEOUT = 1000
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
    ,
    parameter logic [31:0] TRIG_PC     = 32'h0000_3010
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    ext_int_source_if.slave         bus,
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
    input  logic [31:0]             macroscopic_pc,
`endif
    output logic [7:0]              irq_count,
    output logic                    spurious_ack,
    output logic                    ack_late
);

    typedef enum logic [1:0] {
        COUNT,
        PENDING,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] counter;
    logic [31:0] pend_cnt;
    logic        interrupt_q;

    logic        ack_hit;
    logic        trig_now;
    logic [7:0]  count_next;
    logic [31:0] pend_next;
    logic        done_next;

    // An acknowledge is a store of any width to exactly ACK_ADDR; the full
    // 32-bit address is compared so neighbouring bytes do not acknowledge.
    always_comb begin
        ack_hit = (bus.m_int_addr == ACK_ADDR) && (bus.m_int_byteen != 4'b0000);
    end

    // Decide whether the countdown fires on this edge. Testing for <= 1
    // rather than == 1 keeps a zero counter from wrapping around forever.
    always_comb begin
        trig_now = (counter <= 32'd1);
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
        if (macroscopic_pc == TRIG_PC) begin
            trig_now = 1'b1;
        end
`endif
    end

    // Next values of the saturating counters, and whether this acknowledge
    // is the last one before the responder goes quiet.
    always_comb begin
        count_next = (irq_count == 8'hFF) ? 8'hFF : irq_count + 8'd1;
        pend_next  = (pend_cnt == 32'hFFFF_FFFF) ? pend_cnt : pend_cnt + 32'd1;
        done_next  = (MAX_IRQ != 0) && ({24'd0, count_next} == MAX_IRQ);
    end

    // Main controller: countdown, pending with timeout watch, and the
    // terminal DONE state. All outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= COUNT;
            counter      <= FIRST_DELAY;
            pend_cnt     <= 32'd0;
            interrupt_q  <= 1'b0;
            irq_count    <= 8'd0;
            spurious_ack <= 1'b0;
            ack_late     <= 1'b0;
        end else begin
            spurious_ack <= 1'b0;
            case (state)
                COUNT: begin
                    if (ack_hit) begin
                        spurious_ack <= 1'b1;
                    end
                    if (trig_now) begin
                        state       <= PENDING;
                        interrupt_q <= 1'b1;
                        pend_cnt    <= 32'd0;
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                PENDING: begin
                    pend_cnt <= pend_next;
                    if (pend_next >= ACK_TIMEOUT) begin
                        ack_late <= 1'b1;
                    end
                    if (ack_hit) begin
                        interrupt_q <= 1'b0;
                        irq_count   <= count_next;
                        if (done_next) begin
                            state <= DONE;
                        end else begin
                            state   <= COUNT;
                            counter <= PERIOD;
                        end
                    end
                end
                DONE: begin
                    interrupt_q <= 1'b0;
                    if (ack_hit) begin
                        spurious_ack <= 1'b1;
                    end
                end
                default: begin
                    state       <= COUNT;
                    counter     <= FIRST_DELAY;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_ext_int_source.sv
// ---------------------------------------------------------------------------
// tb_ext_int_source
//
// Directed bench for ext_int_source. Instance dut_a uses default parameters;
// instance dut_b uses MAX_IRQ = 2 with short delays. Edge numbers count
// rising clock edges after the most recent reset release.
// ---------------------------------------------------------------------------
module tb_ext_int_source;

    localparam logic [31:0] ACK = 32'h0000_7F20;

    logic clk;
    logic reset_a;
    logic reset_b;
    logic [7:0] irq_count_a;
    logic [7:0] irq_count_b;
    logic spurious_a;
    logic spurious_b;
    logic late_a;
    logic late_b;
    int   edge_cnt;
    int   check_count;
    int   err_count;
    int   rises_b;
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
    logic [31:0] pc_a;
    logic [31:0] pc_b;
`endif

    ext_int_source_if ifa ();
    ext_int_source_if ifb ();

    ext_int_source dut_a (
        .clk            (clk),
        .reset          (reset_a),
        .bus            (ifa),
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
        .macroscopic_pc (pc_a),
`endif
        .irq_count      (irq_count_a),
        .spurious_ack   (spurious_a),
        .ack_late       (late_a)
    );

    ext_int_source #(
        .FIRST_DELAY (10),
        .PERIOD      (20),
        .MAX_IRQ     (2)
    ) dut_b (
        .clk            (clk),
        .reset          (reset_b),
        .bus            (ifb),
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
        .macroscopic_pc (pc_b),
`endif
        .irq_count      (irq_count_b),
        .spurious_ack   (spurious_b),
        .ack_late       (late_b)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every rising edge of dut_b's interrupt request.
    initial rises_b = 0;
    always @(posedge ifb.interrupt) begin
        rises_b <= rises_b + 1;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, actual, expected, edge_cnt);
        end
    endtask

    // Drive a store onto dut_a's interrupt-space port.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be);
        ifa.m_int_addr   = addr;
        ifa.m_int_byteen = be;
    endtask

    // Drive a store onto dut_b's interrupt-space port.
    task automatic applyStimulusB(input logic [31:0] addr, input logic [3:0] be);
        ifb.m_int_addr   = addr;
        ifb.m_int_byteen = be;
    endtask

    // Advance to 1 time unit after rising edge k (counted since release).
    task automatic goto_edge(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    initial begin
        check_count = 0;
        err_count   = 0;
        edge_cnt    = 0;
        reset_a     = 1'b1;
        reset_b     = 1'b1;
        applyStimulus(32'd0, 4'd0);
        applyStimulusB(32'd0, 4'd0);
`ifdef EXT_INT_SOURCE_PC_TRIG_EN
        pc_a = 32'd0;
        pc_b = 32'd0;
`endif
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        checkOutput("rst_interrupt", {31'd0, ifa.interrupt}, 32'd0);
        checkOutput("rst_count", {24'd0, irq_count_a}, 32'd0);
        checkOutput("rst_spurious", {31'd0, spurious_a}, 32'd0);
        checkOutput("rst_late", {31'd0, late_a}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_interrupt", {31'd0, ifa.interrupt}, 32'd0);
        reset_a  = 1'b1;
        edge_cnt = 0;

        // Spurious acknowledge while counting.
        goto_edge(49);
        checkOutput("spur_before", {31'd0, spurious_a}, 32'd0);
        applyStimulus(ACK, 4'b1111);
        goto_edge(50);
        applyStimulus(32'd0, 4'd0);
        checkOutput("spur_pulse", {31'd0, spurious_a}, 32'd1);
        goto_edge(51);
        checkOutput("spur_end", {31'd0, spurious_a}, 32'd0);
        checkOutput("spur_no_irq", {31'd0, ifa.interrupt}, 32'd0);

        // First assertion after edge 100.
        goto_edge(99);
        checkOutput("first_early", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(100);
        checkOutput("first_rise", {31'd0, ifa.interrupt}, 32'd1);
        checkOutput("first_count", {24'd0, irq_count_a}, 32'd0);

        // Acknowledge at edge 110, next assertion after edge 610.
        goto_edge(109);
        applyStimulus(ACK, 4'b1111);
        goto_edge(110);
        applyStimulus(32'd0, 4'd0);
        checkOutput("ack1_irq", {31'd0, ifa.interrupt}, 32'd0);
        checkOutput("ack1_count", {24'd0, irq_count_a}, 32'd1);
        checkOutput("ack1_spur", {31'd0, spurious_a}, 32'd0);
        goto_edge(609);
        checkOutput("second_early", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(610);
        checkOutput("second_rise", {31'd0, ifa.interrupt}, 32'd1);

        // Left pending: ack_late sets after 1000 pending edges.
        goto_edge(1609);
        checkOutput("late_before", {31'd0, late_a}, 32'd0);
        goto_edge(1610);
        checkOutput("late_set", {31'd0, late_a}, 32'd1);
        checkOutput("late_irq_held", {31'd0, ifa.interrupt}, 32'd1);

        // Store held for three edges with a single byte enable.
        goto_edge(1619);
        applyStimulus(ACK, 4'b0001);
        goto_edge(1620);
        checkOutput("held_irq", {31'd0, ifa.interrupt}, 32'd0);
        checkOutput("held_count", {24'd0, irq_count_a}, 32'd2);
        checkOutput("held_spur0", {31'd0, spurious_a}, 32'd0);
        goto_edge(1621);
        checkOutput("held_spur1", {31'd0, spurious_a}, 32'd1);
        goto_edge(1622);
        applyStimulus(32'd0, 4'd0);
        checkOutput("held_spur2", {31'd0, spurious_a}, 32'd1);
        checkOutput("held_count2", {24'd0, irq_count_a}, 32'd2);
        goto_edge(1623);
        checkOutput("held_spur3", {31'd0, spurious_a}, 32'd0);
        checkOutput("late_sticky", {31'd0, late_a}, 32'd1);

        // Neighbouring address while counting is not an acknowledge.
        goto_edge(1999);
        applyStimulus(ACK + 32'd4, 4'b1111);
        goto_edge(2000);
        applyStimulus(32'd0, 4'd0);
        checkOutput("wrong_addr_spur", {31'd0, spurious_a}, 32'd0);

        goto_edge(2120);
        checkOutput("third_rise", {31'd0, ifa.interrupt}, 32'd1);

        // Wrong address and zero byte enables while pending do nothing.
        goto_edge(2129);
        applyStimulus(32'h0000_7F21, 4'b1111);
        goto_edge(2130);
        applyStimulus(ACK, 4'b0000);
        checkOutput("pend_wrong_addr", {31'd0, ifa.interrupt}, 32'd1);
        goto_edge(2131);
        applyStimulus(32'd0, 4'd0);
        checkOutput("pend_zero_be", {31'd0, ifa.interrupt}, 32'd1);
        checkOutput("pend_count", {24'd0, irq_count_a}, 32'd2);

        goto_edge(2134);
        applyStimulus(ACK, 4'b1100);
        goto_edge(2135);
        applyStimulus(32'd0, 4'd0);
        checkOutput("ack3_count", {24'd0, irq_count_a}, 32'd3);
        goto_edge(2640);
        checkOutput("fourth_rise", {31'd0, ifa.interrupt}, 32'd1);

        // Asynchronous reset mid-cycle while pending with irq_count = 3.
        #3;
        reset_a = 1'b0;
        #1;
        checkOutput("mid_rst_irq", {31'd0, ifa.interrupt}, 32'd0);
        checkOutput("mid_rst_count", {24'd0, irq_count_a}, 32'd0);
        checkOutput("mid_rst_late", {31'd0, late_a}, 32'd0);
        checkOutput("mid_rst_spur", {31'd0, spurious_a}, 32'd0);
        @(posedge clk);
        #1;
        reset_a  = 1'b1;
        edge_cnt = 0;
        goto_edge(99);
        checkOutput("restart_early", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(100);
        checkOutput("restart_rise", {31'd0, ifa.interrupt}, 32'd1);

`ifdef EXT_INT_SOURCE_PC_TRIG_EN
        // PC match triggers before FIRST_DELAY expires.
        reset_a = 1'b0;
        #2;
        reset_a  = 1'b1;
        edge_cnt = 0;
        goto_edge(19);
        pc_a = 32'h0000_3010;
        checkOutput("pc_early", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(20);
        pc_a = 32'd0;
        checkOutput("pc_rise", {31'd0, ifa.interrupt}, 32'd1);
        goto_edge(24);
        applyStimulus(ACK, 4'b1111);
        goto_edge(25);
        applyStimulus(32'd0, 4'd0);
        checkOutput("pc_ack", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(524);
        checkOutput("pc_reload_early", {31'd0, ifa.interrupt}, 32'd0);
        goto_edge(525);
        checkOutput("pc_reload_rise", {31'd0, ifa.interrupt}, 32'd1);
`endif

        // dut_b: MAX_IRQ = 2, FIRST_DELAY = 10, PERIOD = 20.
        reset_b  = 1'b1;
        edge_cnt = 0;
        goto_edge(9);
        checkOutput("b_first_early", {31'd0, ifb.interrupt}, 32'd0);
        goto_edge(10);
        checkOutput("b_first_rise", {31'd0, ifb.interrupt}, 32'd1);
        goto_edge(14);
        applyStimulusB(ACK, 4'b1111);
        goto_edge(15);
        applyStimulusB(32'd0, 4'd0);
        checkOutput("b_ack1_irq", {31'd0, ifb.interrupt}, 32'd0);
        checkOutput("b_ack1_count", {24'd0, irq_count_b}, 32'd1);
        goto_edge(34);
        checkOutput("b_second_early", {31'd0, ifb.interrupt}, 32'd0);
        goto_edge(35);
        checkOutput("b_second_rise", {31'd0, ifb.interrupt}, 32'd1);
        goto_edge(39);
        applyStimulusB(ACK, 4'b1111);
        goto_edge(40);
        applyStimulusB(32'd0, 4'd0);
        checkOutput("b_ack2_count", {24'd0, irq_count_b}, 32'd2);
        goto_edge(100);
        checkOutput("b_done_quiet", {31'd0, ifb.interrupt}, 32'd0);
        applyStimulusB(ACK, 4'b1111);
        goto_edge(101);
        applyStimulusB(32'd0, 4'd0);
        checkOutput("b_done_spur", {31'd0, spurious_b}, 32'd1);
        checkOutput("b_done_count", {24'd0, irq_count_b}, 32'd2);
        goto_edge(102);
        checkOutput("b_done_spur_end", {31'd0, spurious_b}, 32'd0);
        checkOutput("b_rises", rises_b, 32'd2);
        checkOutput("b_late", {31'd0, late_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
